// File: rtl/fileReg_pkg.sv
// fileReg_pkg
// Shared definitions for the datapath register blocks of the single-cycle
// processor: default data width, default reset value and the data-word type
// used by every register slice that sits on the write-back bus.
package fileReg_pkg;

  // Default width of a datapath register.
  localparam int unsigned FILEREG_WIDTH_DEF = 8;

  // One datapath word at the default width.
  typedef logic [FILEREG_WIDTH_DEF-1:0] fileRegWord_t;

  // Value a datapath register takes while reset is held.
  localparam fileRegWord_t FILEREG_RST_VAL_DEF = 8'h00;

endpackage : fileReg_pkg

// File: rtl/dff_en_arst.sv
// dff_en_arst
// WIDTH-bit register with a load enable and an asynchronous active-low reset
// that forces RESET_VALUE.
//
// Ports:
//   clk_i   in   1      rising-edge clock
//   rst_ni  in   1      asynchronous reset, active-low
//   en_i    in   1      load enable, sampled on the rising edge
//   d_i     in   WIDTH  data captured when en_i is high
//   q_o     out  WIDTH  stored value
module dff_en_arst
  import fileReg_pkg::*;
#(
  parameter int unsigned           WIDTH       = FILEREG_WIDTH_DEF,
  parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(FILEREG_RST_VAL_DEF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] storeQ;
  logic [WIDTH-1:0] storeD;

  // Next value: take the new data when enabled, otherwise keep what is stored.
  always_comb begin
    storeD = storeQ;
    if (en_i) begin
      storeD = d_i;
    end
  end

  // State register; reset acts immediately, independent of the clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      storeQ <= RESET_VALUE;
    end else begin
      storeQ <= storeD;
    end
  end

  assign q_o = storeQ;

endmodule : dff_en_arst

// File: rtl/microprocessador_ciclo_unico.sv
// microprocessador_ciclo_unico
// File-register slice of the single-cycle processor datapath. The write-back
// stage drives d_in/load; operand readers observe q_out. A loaded value shows
// up on q_out one rising edge after it is written and is held until the next
// load or until reset clears it.
//
// Optional feature (macro FILEREG_BYPASS_EN, undefined by default):
//   When defined, a write-through bypass presents d_in on q_out while load is
//   high and reset is released, so a reader sees the write in the same cycle.
//   Reset still forces RESET_VALUE on q_out.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      asynchronous reset, active-low (0 = in reset)
//   load   in   1      write enable, sampled on the rising edge
//   d_in   in   WIDTH  write data
//   q_out  out  WIDTH  current register contents (or bypassed write data)
module microprocessador_ciclo_unico
  import fileReg_pkg::*;
#(
  parameter int unsigned      WIDTH       = FILEREG_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(FILEREG_RST_VAL_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] regValue;

  dff_en_arst #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_storage (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (load),
    .d_i    (d_in),
    .q_o    (regValue)
  );

`ifdef FILEREG_BYPASS_EN
  // Write-through: forward the incoming word while a write is in progress.
  // During reset regValue is already RESET_VALUE, so gating on reset keeps
  // reset dominant over the bypass.
  always_comb begin
    q_out = regValue;
    if (reset && load) begin
      q_out = d_in;
    end
  end
`else
  assign q_out = regValue;
`endif

endmodule : microprocessador_ciclo_unico

// File: tb/tb_microprocessador_ciclo_unico.sv
// tb_microprocessador_ciclo_unico
// Directed bench for the file-register slice. Stimulus pushes the expected
// q_out (hand-computed) with a short name into a scoreboard; a separate
// monitor pops each entry and compares it against q_out.
module tb_microprocessador_ciclo_unico;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] dIn;
  logic [7:0] qOut;

  string      nameQ[$];
  logic [7:0] expQ[$];
  int         pushCount;
  int         popCount;
  int         checkCount;
  int         passCount;

  microprocessador_ciclo_unico #(
    .WIDTH       (8),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d_in  (dIn),
    .q_out (qOut)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive inputs away from the rising edge.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [7:0] d);
    reset = rst;
    load  = ld;
    dIn   = d;
  endtask

  // Queue an expected q_out value for the monitor.
  task automatic checkOutput(input string name, input logic [7:0] expected);
    nameQ.push_back(name);
    expQ.push_back(expected);
    pushCount++;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares each queued expectation against q_out as it arrives.
  initial begin
    string      n;
    logic [7:0] e;
    forever begin
      wait (pushCount != popCount);
      n = nameQ.pop_front();
      e = expQ.pop_front();
      popCount++;
      checkCount++;
      if (qOut === e) begin
        passCount++;
      end else begin
        $display("[TB] FAIL %s: q_out=%h expected=%h at %0t", n, qOut, e, $time);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not complete (checks=%0d)", checkCount);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    pushCount  = 0;
    popCount   = 0;
    checkCount = 0;
    passCount  = 0;

    // T1: reset clears with no clock edge, even with load high.
    applyStimulus(1'b0, 1'b1, 8'hFF);
    #1;
    checkOutput("t1_reset_immediate", 8'h00);
    tick();
    checkOutput("t1_reset_over_load", 8'h00);

    // T2: single load of AA, then held for 10 edges.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'hAA);
    tick();
    checkOutput("t2_load_aa", 8'hAA);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput($sformatf("t2_hold_%0d", i), 8'hAA);
    end

    // T3: d_in toggles with load low; stored value unaffected.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, (i % 2 == 0) ? 8'h3C : 8'hC3);
      tick();
      checkOutput($sformatf("t3_hold_%0d", i), 8'hAA);
    end

    // T4: asynchronous reset pulse between edges clears the stored word.
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t4_reset_async", 8'h00);
    #9;
    reset = 1'b1;
    tick();
    checkOutput("t4_after_release", 8'h00);

    // T5: reload 55, then reset wins over a simultaneous load.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h55);
    tick();
    checkOutput("t5_load_55", 8'h55);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'h77);
    #1;
    checkOutput("t5_reset_immediate", 8'h00);
    tick();
    checkOutput("t5_reset_priority", 8'h00);

    // Load held high across several edges: last sampled value wins.
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h12);
    tick();
    checkOutput("track_12", 8'h12);
    @(negedge clk);
    dIn = 8'h34;
    tick();
    checkOutput("track_34", 8'h34);
    @(negedge clk);
    dIn = 8'h56;
    tick();
    checkOutput("track_56", 8'h56);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'hE7);
    tick();
    checkOutput("track_hold_56", 8'h56);

    // T6: write-through bypass (only visible when the bypass is built in).
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h99);
    #1;
`ifdef FILEREG_BYPASS_EN
    checkOutput("t6_bypass_before_edge", 8'h99);
`else
    checkOutput("t6_no_bypass_before_edge", 8'h56);
`endif
    tick();
    load = 1'b0;
    dIn  = 8'h11;
    #1;
    checkOutput("t6_after_edge", 8'h99);
`ifdef FILEREG_BYPASS_EN
    // Reset must still win over the bypass.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'h42);
    #1;
    checkOutput("t6_reset_over_bypass", 8'h00);
    reset = 1'b1;
    load  = 1'b0;
`endif

    // Let the monitor drain, then confirm nothing was left unchecked.
    #3;
    checkCount++;
    if (pushCount == popCount) begin
      passCount++;
    end else begin
      $display("[TB] FAIL scoreboard_drain: popped=%0d pushed=%0d", popCount, pushCount);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_microprocessador_ciclo_unico
